ahb_out_arb: RTL and testbench

AHB_OUT_ARB -- requirements
Module: ahb_out_arb

---
 rtl/ahb_arb_pkg.sv | 35 +++
 rtl/ahb_arb_burst_cnt.sv | 78 +++++++
 rtl/ahb_out_arb.sv | 115 +++++++++++
 tb/tb_ahb_out_arb.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and burst-length helper for the output-port arbiter.
// Used by ahb_out_arb and ahb_arb_burst_cnt.
package ahb_arb_pkg;

   typedef enum logic [1:0] {
      HT_IDLE   = 2'b00,
      HT_BUSY   = 2'b01,
      HT_NONSEQ = 2'b10,
      HT_SEQ    = 2'b11
   } htrans_e;

   typedef enum logic [2:0] {
      HB_SINGLE = 3'd0,
      HB_INCR   = 3'd1,
      HB_WRAP4  = 3'd2,
      HB_INCR4  = 3'd3,
      HB_WRAP8  = 3'd4,
      HB_INCR8  = 3'd5,
      HB_WRAP16 = 3'd6,
      HB_INCR16 = 3'd7
   } hburst_e;

   // Beats still to come after the NONSEQ and the next beat (L-2).
   function automatic logic [3:0] burst_remain(input hburst_e b,
                                               input logic [3:0] incr_rem);
      case (b)
         HB_WRAP4, HB_INCR4:   return 4'd2;
         HB_WRAP8, HB_INCR8:   return 4'd6;
         HB_WRAP16, HB_INCR16: return 4'd14;
         HB_INCR:              return incr_rem;
         default:              return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arb_burst_cnt.sv
// Burst tracker: remaining beats, hold flag and early-INCR counter.
// Exposes the next-state hold used to freeze arbitration.
module ahb_arb_burst_cnt
   import ahb_arb_pkg::*;
#(
   parameter int INCR_BEATS       = 4,
   parameter int EARLY_INCR_LIMIT = 1
) (
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic       HREADYM,
   input  logic       HSELM,
   input  logic [1:0] HTRANSM,
   input  logic [2:0] HBURSTM,
   output logic       hold_nxt_o
);

   localparam logic [3:0] INCR_REM  = 4'(INCR_BEATS - 2);
   localparam logic [1:0] EARLY_LIM = 2'(EARLY_INCR_LIMIT);

   logic [3:0] remain_q, remain_d;
   logic       hold_q, hold_d;
   logic [1:0] early_q, early_d;
   htrans_e    trans;
   hburst_e    burst;

   assign trans = htrans_e'(HTRANSM);
   assign burst = hburst_e'(HBURSTM);

   always_comb begin
      remain_d = remain_q;
      hold_d   = hold_q;
      if (!HSELM || trans == HT_IDLE) begin
         remain_d = '0;
         hold_d   = 1'b0;
      end else begin
         case (trans)
            HT_NONSEQ: begin
               remain_d = burst_remain(burst, INCR_REM);
               hold_d   = (burst != HB_SINGLE);
               // Repeatedly cut-short INCRs lose their hold.
               if (burst == HB_INCR && early_q == EARLY_LIM) begin
                  remain_d = '0;
                  hold_d   = 1'b0;
               end
            end
            HT_SEQ: begin
               if (remain_q != 4'd0) remain_d = remain_q - 4'd1;
               else                  hold_d   = 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      early_d = early_q;
      if (!hold_d)
         early_d = '0;
      else if (trans == HT_NONSEQ && hold_q && early_q != 2'd3)
         early_d = early_q + 2'd1;
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         remain_q <= '0;
         hold_q   <= 1'b0;
         early_q  <= '0;
      end else if (HREADYM) begin
         remain_q <= remain_d;
         hold_q   <= hold_d;
         early_q  <= early_d;
      end
   end

   assign hold_nxt_o = hold_d;

endmodule

// File: rtl/ahb_out_arb.sv
// Round-robin arbiter for one shared AHB output port with burst hold.
// Optional hi_pri QoS input enabled by AHB_OUT_ARB_QOS_EN.
module ahb_out_arb
   import ahb_arb_pkg::*;
#(
   parameter int NUM_PORTS        = 4,
   parameter int INCR_BEATS       = 4,
   parameter int EARLY_INCR_LIMIT = 1,
   localparam int PORT_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   input  logic [NUM_PORTS-1:0] req_port,
`ifdef AHB_OUT_ARB_QOS_EN
   input  logic [NUM_PORTS-1:0] hi_pri,
`endif
   input  logic                 HREADYM,
   input  logic                 HSELM,
   input  logic [1:0]           HTRANSM,
   input  logic [2:0]           HBURSTM,
   input  logic                 HMASTLOCKM,
   output logic [PORT_W-1:0]    addr_in_port,
   output logic [NUM_PORTS-1:0] addr_in_port_oh,
   output logic                 no_port
);

   logic [PORT_W-1:0]    addr_q, addr_d;
   logic                 no_port_q, no_port_d;
   logic                 np_eff, idx_ok, hold_nxt;
   logic [NUM_PORTS-1:0] hp_mask;
   logic                 f_rr, f_hp;
   logic [PORT_W-1:0]    i_rr, i_hp;

`ifdef AHB_OUT_ARB_QOS_EN
   assign hp_mask = hi_pri;
`else
   assign hp_mask = '0;
`endif

   ahb_arb_burst_cnt #(
      .INCR_BEATS       (INCR_BEATS),
      .EARLY_INCR_LIMIT (EARLY_INCR_LIMIT)
   ) u_cnt (
      .HCLK       (HCLK),
      .HRESET     (HRESET),
      .HREADYM    (HREADYM),
      .HSELM      (HSELM),
      .HTRANSM    (HTRANSM),
      .HBURSTM    (HBURSTM),
      .hold_nxt_o (hold_nxt)
   );

   // First requester in lowest-index order, or round-robin after c.
   function automatic logic [PORT_W:0] pick(input logic [NUM_PORTS-1:0] m,
                                            input logic np,
                                            input logic [PORT_W-1:0] c);
      logic              found;
      logic [PORT_W-1:0] idx;
      int                j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         j = np ? k : (int'(c) + 1 + k) % NUM_PORTS;
         if (!found && m[j] && (np || j != int'(c))) begin
            found = 1'b1;
            idx   = PORT_W'(j);
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      idx_ok = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (addr_q == PORT_W'(i)) idx_ok = 1'b1;
   end

   assign np_eff = no_port_q | ~idx_ok;

   always_comb begin
      {f_hp, i_hp} = pick(req_port & hp_mask, np_eff, addr_q);
      {f_rr, i_rr} = pick(req_port, np_eff, addr_q);
      no_port_d = 1'b1;
      addr_d    = addr_q;
      if (f_hp) begin
         no_port_d = 1'b0;
         addr_d    = i_hp;
      end else if (f_rr) begin
         no_port_d = 1'b0;
         addr_d    = i_rr;
      end else if (!np_eff && HSELM) begin
         no_port_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         no_port_q <= 1'b1;
         addr_q    <= '0;
      end else if (HREADYM && !(HMASTLOCKM || hold_nxt)) begin
         no_port_q <= no_port_d;
         addr_q    <= addr_d;
      end
   end

   always_comb begin
      addr_in_port_oh = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         addr_in_port_oh[i] = !np_eff && (addr_q == PORT_W'(i));
   end

   assign addr_in_port = addr_q;
   assign no_port      = np_eff;

endmodule

// File: tb/tb_ahb_out_arb.sv
// Self-checking bench for ahb_out_arb: directed cases plus random traffic
// against a behavioural model of grant, burst hold and early-INCR rules.
module tb_ahb_out_arb;

   localparam int N   = 4;
   localparam int IB  = 4;
   localparam int LIM = 1;
`ifdef AHB_OUT_ARB_QOS_EN
   localparam bit QOS = 1'b1;
`else
   localparam bit QOS = 1'b0;
`endif

   logic         HCLK = 1'b0;
   logic         HRESET;
   logic [N-1:0] req_port, hi_pri;
   logic         HREADYM, HSELM, HMASTLOCKM;
   logic [1:0]   HTRANSM;
   logic [2:0]   HBURSTM;
   logic [1:0]   addr_in_port;
   logic [N-1:0] addr_in_port_oh;
   logic         no_port;

   int tests = 0;
   int fails = 0;

   // Model state: grant, beats left, hold flag, early counter.
   bit m_np;
   int m_addr;
   int m_rem;
   bit m_hold;
   int m_early;

   always #5 HCLK = ~HCLK;

   ahb_out_arb dut (
      .HCLK            (HCLK),
      .HRESET          (HRESET),
      .req_port        (req_port),
`ifdef AHB_OUT_ARB_QOS_EN
      .hi_pri          (hi_pri),
`endif
      .HREADYM         (HREADYM),
      .HSELM           (HSELM),
      .HTRANSM         (HTRANSM),
      .HBURSTM         (HBURSTM),
      .HMASTLOCKM      (HMASTLOCKM),
      .addr_in_port    (addr_in_port),
      .addr_in_port_oh (addr_in_port_oh),
      .no_port         (no_port)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int  nrem, ne, len, win;
      bit  nh;
      int  order[$];
      if (HRESET) begin
         m_np = 1'b1; m_addr = 0; m_rem = 0; m_hold = 1'b0; m_early = 0;
         return;
      end
      if (!HREADYM) return;
      nrem = m_rem;
      nh   = m_hold;
      if (!HSELM || HTRANSM == 2'd0) begin
         nrem = 0; nh = 1'b0;
      end else if (HTRANSM == 2'd2) begin
         if (HBURSTM == 3'd0) begin
            nrem = 0; nh = 1'b0;
         end else if (HBURSTM == 3'd1) begin
            if (m_early == LIM) begin nrem = 0; nh = 1'b0; end
            else begin nrem = IB - 2; nh = 1'b1; end
         end else begin
            len  = (HBURSTM < 3'd4) ? 4 : (HBURSTM < 3'd6) ? 8 : 16;
            nrem = len - 2;
            nh   = 1'b1;
         end
      end else if (HTRANSM == 2'd3) begin
         if (m_rem != 0) nrem = m_rem - 1;
         else            nh = 1'b0;
      end
      if (!nh) ne = 0;
      else if (HTRANSM == 2'd2 && m_hold) ne = (m_early < 3) ? m_early + 1 : 3;
      else ne = m_early;
      if (!(HMASTLOCKM || nh)) begin
         for (int k = 0; k < (m_np ? N : N - 1); k++)
            order.push_back(((m_np ? 0 : m_addr + 1) + k) % N);
         win = -1;
         if (QOS)
            foreach (order[i])
               if (win < 0 && req_port[order[i]] && hi_pri[order[i]]) win = order[i];
         foreach (order[i])
            if (win < 0 && req_port[order[i]]) win = order[i];
         if (win >= 0) begin m_np = 1'b0; m_addr = win; end
         else if (!(!m_np && HSELM)) m_np = 1'b1;
      end
      m_rem = nrem; m_hold = nh; m_early = ne;
   endtask

   task automatic step(input string tag);
      @(posedge HCLK);
      model_edge();
      @(negedge HCLK);
      chk({tag, ":np"}, 32'(no_port), 32'(m_np));
      chk({tag, ":addr"}, 32'(addr_in_port), 32'(m_addr));
      chk({tag, ":oh"}, 32'(addr_in_port_oh), m_np ? 32'd0 : 32'(1 << m_addr));
   endtask

   task automatic go(input logic [N-1:0] r, input logic rdy, input logic sel,
                     input logic [1:0] tr, input logic [2:0] bu, input logic lk);
      HRESET = 1'b0; req_port = r; HREADYM = rdy; HSELM = sel;
      HTRANSM = tr; HBURSTM = bu; HMASTLOCKM = lk;
   endtask

   task automatic do_reset();
      go('0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0);
      HRESET = 1'b1;
      step("rst");
      HRESET = 1'b0;
   endtask

   initial begin
      hi_pri = '0;
      do_reset();
      chk("reset_np", 32'(no_port), 32'd1);
      chk("reset_hold", 32'(dut.u_cnt.hold_q), 32'd0);

      // Round-robin sweep from grant 1
      go(4'b0010, 1, 1, 2'd0, 3'd0, 0); step("rr0");
      go(4'b1101, 1, 1, 2'd0, 3'd0, 0); step("rr1");
      chk("rr_grant2", 32'(addr_in_port), 32'd2);
      step("rr2");
      chk("rr_grant3", 32'(addr_in_port), 32'd3);

      // INCR8 from port 0 holds the grant for all eight beats
      do_reset();
      go(4'b0001, 1, 1, 2'd0, 3'd0, 0); step("i8g");
      go(4'b0101, 1, 1, 2'd2, 3'd5, 0); step("i8b1");
      for (int b = 2; b <= 7; b++) begin
         HTRANSM = 2'd3; step("i8seq");
         chk("i8_hold", 32'(addr_in_port), 32'd0);
      end
      step("i8b8");
      chk("i8_switch", 32'(addr_in_port), 32'd2);

      // Back-to-back short INCRs lose hold once early count hits limit
      do_reset();
      go(4'b0010, 1, 1, 2'd0, 3'd0, 0); step("inc_g");
      go(4'b1010, 1, 1, 2'd2, 3'd1, 0); step("inc_n1");
      HTRANSM = 2'd3; step("inc_s1");
      HTRANSM = 2'd2; step("inc_n2");
      chk("inc_held", 32'(addr_in_port), 32'd1);
      HTRANSM = 2'd3; step("inc_s2");
      HTRANSM = 2'd2; step("inc_n3");
      chk("inc_unheld", 32'(addr_in_port), 32'd3);

      // Own-port-only request, then deselect, then no requests
      go(4'b1000, 1, 1, 2'd0, 3'd0, 0); step("own_sel");
      chk("own_stay", 32'(addr_in_port), 32'd3);
      HSELM = 1'b0; step("own_nosel");
      chk("own_np", 32'(no_port), 32'd1);
      chk("own_addr_kept", 32'(addr_in_port), 32'd3);
      req_port = '0; step("noreq");
      go(4'b1001, 1, 1, 2'd0, 3'd0, 0); step("lowest");
      chk("lowest_wins", 32'(addr_in_port), 32'd0);

      // Lock with wait states freezes the grant
      go(4'b1110, 0, 1, 2'd0, 3'd0, 1);
      for (int c = 0; c < 3; c++) begin
         step("lk_wait");
         chk("lk_frozen", 32'(addr_in_port), 32'd0);
      end
      HREADYM = 1'b1; step("lk_rdy");
      chk("lk_still", 32'(addr_in_port), 32'd0);
      HMASTLOCKM = 1'b0; step("lk_drop");
      chk("lk_switch", 32'(addr_in_port), 32'd1);

      // Reset during beat 5 of an INCR16
      do_reset();
      go(4'b0001, 1, 1, 2'd0, 3'd0, 0); step("r16g");
      go(4'b0111, 1, 1, 2'd2, 3'd7, 0); step("r16b1");
      HTRANSM = 2'd3;
      for (int b = 2; b <= 4; b++) step("r16seq");
      HRESET = 1'b1; step("r16rst");
      chk("r16_np", 32'(no_port), 32'd1);
      chk("r16_addr", 32'(addr_in_port), 32'd0);
      chk("r16_oh", 32'(addr_in_port_oh), 32'd0);
      chk("r16_hold", 32'(dut.u_cnt.hold_q), 32'd0);
      go(4'b0100, 1, 1, 2'd0, 3'd0, 0); step("r16post");
      chk("r16_first", 32'(addr_in_port), 32'd2);

`ifdef AHB_OUT_ARB_QOS_EN
      do_reset();
      go(4'b0001, 1, 1, 2'd0, 3'd0, 0); step("qg");
      go(4'b0110, 1, 1, 2'd0, 3'd0, 0); hi_pri = 4'b0100; step("qsel");
      chk("qos_hi_wins", 32'(addr_in_port), 32'd2);
`endif

      // Random traffic against the model
      for (int c = 0; c < 2000; c++) begin
         req_port   = 4'($urandom);
         hi_pri     = 4'($urandom);
         HREADYM    = ($urandom_range(0, 3) != 0);
         HSELM      = ($urandom_range(0, 7) != 0);
         HTRANSM    = 2'($urandom);
         HBURSTM    = 3'($urandom);
         HMASTLOCKM = ($urandom_range(0, 15) == 0);
         HRESET     = ($urandom_range(0, 63) == 0);
         step("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
